// File: rtl/row_clear_pkg.sv
// Shared types and default geometry for the row clear engine.
// Optional lifetime statistics are built when ROW_CLEAR_STATS_EN is defined.
package row_clear_pkg;

  localparam int NR_OF_BITS  = 10;
  localparam int NR_OF_ROWS  = 20;
  localparam int ADDR_BITS   = 5;
  localparam int TOTAL_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    FILL,
    DONE
  } state_t;

endpackage

// File: rtl/row_clear_if.sv
// Bundle of control and row-RAM signals between the sequencer/RAM side (master)
// and the row clear engine (slave).
interface row_clear_if #(
  parameter int NrOfBits   = 10,
  parameter int AddrBits   = 5,
  parameter int TotalWidth = 16
) ();

  logic                  Start;
  logic [NrOfBits-1:0]   Rd_Data;
  logic [NrOfBits-1:0]   Empty_Mask;
  logic                  Rd_En;
  logic [AddrBits-1:0]   Rd_Addr;
  logic                  Wr_En;
  logic [AddrBits-1:0]   Wr_Addr;
  logic [NrOfBits-1:0]   Wr_Data;
  logic                  Busy;
  logic                  Done;
  logic [AddrBits:0]     Lines_Cleared;
  logic [TotalWidth-1:0] Total_Lines;

  modport master (
    output Start, Rd_Data, Empty_Mask,
    input  Rd_En, Rd_Addr, Wr_En, Wr_Addr, Wr_Data, Busy, Done,
           Lines_Cleared, Total_Lines
  );

  modport slave (
    input  Start, Rd_Data, Empty_Mask,
    output Rd_En, Rd_Addr, Wr_En, Wr_Addr, Wr_Data, Busy, Done,
           Lines_Cleared, Total_Lines
  );

endinterface

// File: rtl/row_clear_stats.sv
// Saturating accumulator of lines cleared over the lifetime of the part
// (instantiated only when ROW_CLEAR_STATS_EN is defined).
module row_clear_stats #(
  parameter int Width  = 16,
  parameter int InBits = 6
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              add_en,
  input  logic [InBits-1:0] add_val,
  output logic [Width-1:0]  total
);

  logic [Width-1:0] total_reg;
  logic [Width:0]   sum;

  assign sum = {1'b0, total_reg} + {{(Width + 1 - InBits){1'b0}}, add_val};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      total_reg <= '0;
    end else if (add_en) begin
      total_reg <= sum[Width] ? {Width{1'b1}} : sum[Width-1:0];
    end
  end

  assign total = total_reg;

endmodule

// File: rtl/row_clear_engine.sv
// Compacts the playfield after a lock: full rows are dropped, survivors slide down,
// freed top rows are zeroed. Define ROW_CLEAR_STATS_EN for the lifetime Total_Lines counter.
module row_clear_engine
  import row_clear_pkg::*;
#(
  parameter int NrOfBits = NR_OF_BITS,
  parameter int NrOfRows = NR_OF_ROWS,
  parameter int AddrBits = ADDR_BITS
) (
  input  logic         Clock,
  input  logic         Reset_n,
  row_clear_if.slave   bus
);

  localparam logic [AddrBits-1:0] LAST_ROW = AddrBits'(NrOfRows - 1);
  localparam logic [AddrBits-1:0] ADDR_ONE = AddrBits'(1);
  localparam logic [AddrBits:0]   CNT_ONE  = (AddrBits + 1)'(1);

  state_t              state_reg, state_next;
  logic [AddrBits-1:0] src_reg, src_next;
  logic [AddrBits-1:0] dst_reg, dst_next;
  logic [AddrBits:0]   count_reg, count_next;
  logic [AddrBits:0]   lines_reg, lines_next;
  logic                wr_en;
  logic [NrOfBits-1:0] wr_data;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
      lines_reg <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      count_reg <= count_next;
      lines_reg <= lines_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    count_next = count_reg;
    lines_next = lines_reg;
    wr_en      = 1'b0;
    wr_data    = '0;
    case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          state_next = READ;
          src_next   = '0;
          dst_next   = '0;
          count_next = '0;
        end
      end
      READ: state_next = CHECK;
      CHECK: begin
        if (bus.Empty_Mask == '0) begin
          count_next = count_reg + CNT_ONE;
        end else begin
          // Rows below the first full row already sit in place; skip the rewrite.
          if (src_reg != dst_reg) begin
            wr_en   = 1'b1;
            wr_data = bus.Rd_Data;
          end
          dst_next = dst_reg + ADDR_ONE;
        end
        src_next = src_reg + ADDR_ONE;
        if (src_reg == LAST_ROW) begin
          if (count_next != '0) begin
            state_next = FILL;
          end else begin
            state_next = DONE;
            lines_next = count_next;
          end
        end else begin
          state_next = READ;
        end
      end
      FILL: begin
        wr_en    = 1'b1;
        dst_next = dst_reg + ADDR_ONE;
        if (dst_reg == LAST_ROW) begin
          state_next = DONE;
          lines_next = count_reg;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.Rd_En         = (state_reg == READ);
  assign bus.Rd_Addr       = src_reg;
  assign bus.Wr_En         = wr_en;
  assign bus.Wr_Addr       = dst_reg;
  assign bus.Wr_Data       = wr_data;
  assign bus.Busy          = (state_reg == READ) || (state_reg == CHECK) || (state_reg == FILL);
  assign bus.Done          = (state_reg == DONE);
  assign bus.Lines_Cleared = lines_reg;

`ifdef ROW_CLEAR_STATS_EN
  row_clear_stats #(
    .Width  (TOTAL_WIDTH),
    .InBits (AddrBits + 1)
  ) u_stats (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .add_en  (state_reg == DONE),
    .add_val (lines_reg),
    .total   (bus.Total_Lines)
  );
`else
  assign bus.Total_Lines = '0;
`endif

endmodule

// File: tb/tb_row_clear_engine.sv
// Scoreboard bench: a behavioural row RAM feeds the engine; expected writes are
// queued per run and popped as the engine writes, then final field contents are compared.
module tb_row_clear_engine;
  import row_clear_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  row_clear_if #(.NrOfBits(NR_OF_BITS), .AddrBits(ADDR_BITS), .TotalWidth(TOTAL_WIDTH)) bus ();

  row_clear_engine dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  logic [9:0]  ram [32];
  logic [9:0]  img [20];
  logic [9:0]  exp_final [20];
  logic        load_req = 1'b0;
  logic [14:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  assign bus.Empty_Mask = ~bus.Rd_Data;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 20; i++) ram[i] <= img[i];
    end else if (bus.Wr_En) begin
      ram[bus.Wr_Addr] <= bus.Wr_Data;
    end
    if (bus.Rd_En) bus.Rd_Data <= ram[bus.Rd_Addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Fill img: rows [full_lo, full_hi] full, the rest random but never full.
  task automatic make_img(input int full_lo, input int full_hi);
    for (int i = 0; i < 20; i++)
      img[i] = (i >= full_lo && i <= full_hi) ? 10'h3FF : 10'($urandom_range(0, 1022));
  endtask

  task automatic run_case(input string name, input int start_at, input int reset_at);
    int cnt, dst, cyc, done_cyc, busy_err, bad_rows;
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    exp_q.delete();
    cnt = 0;
    dst = 0;
    for (int s = 0; s < 20; s++) begin
      if (img[s] == 10'h3FF) cnt++;
      else begin
        if (s != dst) exp_q.push_back({5'(dst), img[s]});
        exp_final[dst] = img[s];
        dst++;
      end
    end
    if (cnt == 0) begin
      for (int i = 0; i < 20; i++) exp_final[i] = img[i];
    end else begin
      for (int d = dst; d < 20; d++) begin
        exp_q.push_back({5'(d), 10'h000});
        exp_final[d] = 10'h000;
      end
    end
    @(negedge clk) bus.Start = 1'b1;
    @(negedge clk) bus.Start = 1'b0;
    cyc = 1;
    done_cyc = 0;
    busy_err = 0;
    while (cyc < 200) begin
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check({name, "_reset_strobes"}, {29'd0, bus.Busy, bus.Rd_En, bus.Wr_En}, 32'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        check({name, "_reset_lines"}, 32'(bus.Lines_Cleared), 32'd0);
        $display("run %s reset at cycle %0d", name, cyc);
        exp_q.delete();
        return;
      end
      if (bus.Wr_En) begin
        if (exp_q.size() == 0) check({name, "_extra_write"}, {17'd0, bus.Wr_Addr, bus.Wr_Data}, 32'h7FFF);
        else check({name, "_write"}, {17'd0, bus.Wr_Addr, bus.Wr_Data}, 32'(exp_q.pop_front()));
      end
      if (bus.Done) begin
        done_cyc = cyc;
        check({name, "_busy_in_done"}, 32'(bus.Busy), 32'd0);
        break;
      end
      if (!bus.Busy) busy_err++;
      bus.Start = (cyc == start_at);
      @(negedge clk);
      cyc++;
    end
    bus.Start = 1'b0;
    check({name, "_done_cycle"}, 32'(done_cyc), 32'(41 + cnt));
    check({name, "_busy_err"}, 32'(busy_err), 32'd0);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({name, "_lines"}, 32'(bus.Lines_Cleared), 32'(cnt));
    bad_rows = 0;
    for (int i = 0; i < 20; i++) if (ram[i] !== exp_final[i]) bad_rows++;
    check({name, "_field"}, 32'(bad_rows), 32'd0);
    if (start_at > 0) begin
      repeat (3) @(negedge clk);
      check({name, "_start_not_queued"}, 32'(bus.Busy), 32'd0);
    end
    $display("run %s cleared=%0d done_cycle=%0d", name, bus.Lines_Cleared, done_cyc);
  endtask

  initial begin
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {10'd0, bus.Busy, bus.Done, bus.Rd_En, bus.Wr_En, bus.Rd_Addr, bus.Wr_Addr, bus.Wr_Data},
          32'd0);
    check("reset_lines", 32'(bus.Lines_Cleared), 32'd0);
    check("reset_total", 32'(bus.Total_Lines), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    make_img(-1, -1);  run_case("no_full", 0, 0);
    make_img(0, 0);    run_case("row0", 0, 0);
    make_img(3, 6);    run_case("rows3_6", 0, 0);
    make_img(0, 19);   run_case("all_full", 0, 0);
    make_img(3, 6);    run_case("start_ignored", 5, 0);
    make_img(2, 4);    run_case("interrupted", 0, 10);
    check("total_after_reset", 32'(bus.Total_Lines), 32'd0);
    make_img(3, 6);    run_case("after_reset", 0, 0);
    make_img(0, 0);    run_case("second", 0, 0);
`ifdef ROW_CLEAR_STATS_EN
    check("total_lines", 32'(bus.Total_Lines), 32'd5);
`else
    check("total_lines", 32'(bus.Total_Lines), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_clear_engine.md
# row_clear_engine

- Consumes the per-row empty mask from the playfield inverter stage, which drives Empty_Mask as the bitwise NOT of row occupancy.
- Compacts the Tetris playfield after a piece locks: full rows are removed, surviving rows shift down, and freed top rows are zeroed.
- Sits between the playfield row RAM and the game-control sequencer.
- Reports how many lines were cleared.

## Interface
- NrOfBits, 10: cells per row.
- NrOfRows, 20: rows in the playfield; row 0 is the bottom row.
- AddrBits, 5: row address width; must satisfy 2^AddrBits >= NrOfRows.
- Clock  in  1  the single clock; all state changes on its rising edge.
- Reset_n  in  1  reset, asynchronous and active-low.
- Start  in  1  one-cycle request to begin compaction; accepted only in IDLE.
- Rd_Data  in  NrOfBits  row occupancy; valid one cycle after Rd_En.
- Empty_Mask  in  NrOfBits  equals ~Rd_Data, from the inverter stage; the row is full when this is all zeros.
- Rd_En  out  1  row RAM read strobe.
- Rd_Addr  out  AddrBits  row RAM read address.
- Wr_En  out  1  row RAM write strobe.
- Wr_Addr  out  AddrBits  row RAM write address.
- Wr_Data  out  NrOfBits  row RAM write data.
- Busy  out  1  compaction in progress.
- Done  out  1  one-cycle completion pulse.
- Lines_Cleared  out  AddrBits+1  full rows removed by the last run; holds until the next accepted Start.
- Total_Lines  out  16  lifetime lines cleared; present only under the configuration macro (see Configuration).

## Operation
- Two row pointers: Src reads rows 0 to NrOfRows-1; Dst is the next write target. Both are 0 at Start.
- FSM states: IDLE, READ, CHECK, FILL, DONE.
- IDLE: all strobes low. Start=1 moves to READ and clears Src, Dst and the internal line count. Lines_Cleared is not cleared here.
- READ: Rd_En=1, Rd_Addr=Src, then go to CHECK.
- CHECK: evaluate Empty_Mask.
  - Empty_Mask==0 (full row): no write; count+1.
  - Otherwise (surviving row): if Src!=Dst, Wr_En=1, Wr_Addr=Dst, Wr_Data=Rd_Data. Dst+1 in either case.
  - After CHECK, Src+1. If Src was NrOfRows-1, go to FILL when count>0, or to DONE when count==0. Otherwise return to READ.
- FILL: Wr_En=1, Wr_Addr=Dst, Wr_Data=0, then Dst+1. Leave for DONE after the write to row NrOfRows-1.
- DONE: Done=1; Lines_Cleared updated to count; return to IDLE.
- Start while Busy=1 is ignored; it is neither queued nor does it restart the run.
- Rows below the first full row are never written.
- Reset mid-run: the FSM returns to IDLE immediately and the RAM is left partially compacted. The sequencer must reload the field.

## Timing
- Reset values: Busy, Done, Rd_En, Wr_En = 0; Rd_Addr, Wr_Addr, Wr_Data = 0; Lines_Cleared = 0; Total_Lines = 0.
- Cycle numbering: Start is sampled at edge 0.
  - Rows: READ and CHECK occupy cycles 1 to 2·NrOfRows.
  - Fill: k fill cycles follow, where k = count.
  - Done: high in cycle 2·NrOfRows+k+1.
- Busy is high in cycles 1 to 2·NrOfRows+k and low in the DONE cycle. A new Start is accepted in the cycle after DONE.
- Read latency is exactly 1 cycle; Empty_Mask must be valid in the same cycle as Rd_Data.
- All outputs are registered-state decodes, with no combinational path from Start.

## Configuration
- Macro: ROW_CLEAR_STATS_EN.
- When defined: Total_Lines adds Lines_Cleared in the DONE cycle, saturating at 16'hFFFF. It is cleared only by reset.
- When undefined: the counter is absent and Total_Lines is tied to 0.

## Structure
- Package row_clear_pkg holds:
  - the state enum {IDLE, READ, CHECK, FILL, DONE};
  - the default NrOfBits, NrOfRows and AddrBits constants;
  - the Total_Lines width constant (16).
- Sub-module row_clear_stats contains the saturating accumulator. It is instantiated only under ROW_CLEAR_STATS_EN.

## Test plan
- No full rows, default parameters, Start → zero Wr_En pulses, Done in cycle 41, Lines_Cleared=0.
- Row 0 full only → rows 1-19 are written to 0-18 and row 19 is zeroed (20 writes total), Lines_Cleared=1, Done in cycle 42.
- Rows 3-6 full → rows 7-19 move to 3-15, rows 16-19 are zeroed, rows 0-2 are never written, Lines_Cleared=4, Done in cycle 45.
- All 20 rows full → 20 fill writes to rows 0-19, Lines_Cleared=20, Done in cycle 61.
- Interrupted run:
  - Start at cycle 5 of a run is ignored.
  - Reset_n low in cycle 10 drops Busy, Rd_En and Wr_En immediately.
  - After release, a fresh Start runs to Done normally.
- With ROW_CLEAR_STATS_EN: runs clearing 4 then 1 give Total_Lines=5; starting from 65534, a run clearing 4 gives 65535.
